// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   - FSM state constants for the transmitter
//   - odd-parity helper
//   - common keyboard command / response bytes
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // PS/2 parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: command handshake and PS/2 line signals of the host transmitter.
//   tx_data/tx_valid/tx_ready : byte request handshake
//   tx_done/tx_error          : end-of-transfer pulse and status
//   ps2_clk_in/ps2_data_in    : raw line states
//   ps2_clk_oe/ps2_data_oe    : active-high pull-low enables for the open-drain lines
// master = controller plus line environment, slave = ps2_tx.
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions the raw PS/2 lines.
//   clk, reset      : system clock, async active-high reset
//   i_clk_raw       : raw PS/2 clock line
//   i_data_raw      : raw PS/2 data line
//   o_clk_s/o_data_s: 2-flop synchronised line states
//   o_fall/o_rise   : debounced clock edges, FILTER_LEN/2+2 cycles after the line moves
// FILTER_LEN must be even.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_fall,
  output logic o_rise
);

  // Older samples in the upper half, newest in bit 0: ones-then-zeros is a fall.
  localparam logic [FILTER_LEN-1:0] FALL_PAT =
    {{(FILTER_LEN/2){1'b1}}, {(FILTER_LEN/2){1'b0}}};

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_hist;

  // Idle lines are high; resetting to ones avoids a phantom rise after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_hist      <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
      r_data_sync <= {r_data_sync[0], i_data_raw};
      r_hist      <= {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
    end
  end

  assign o_clk_s  = r_clk_sync[1];
  assign o_data_s = r_data_sync[1];
  assign o_fall   = (r_hist == FALL_PAT);
  assign o_rise   = (r_hist == ~FALL_PAT);

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
//   clk, reset : system clock, async active-high reset
//   bus        : ps2_tx_if slave - tx_data/tx_valid/tx_ready request handshake,
//                tx_done/tx_error completion, raw line inputs and pull-low enables.
// Sequence: hold clock low INHIBIT_CYCLES (start bit asserted in the last cycle),
// release clock, shift 8 data bits LSB first + odd parity + stop on device clock
// falls, sample the device ACK on the following fall, then wait for an idle bus.
// Any gap of TIMEOUT_CYCLES without a device clock edge aborts with tx_error=1.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2600,
  parameter int unsigned TIMEOUT_CYCLES = 400000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input logic      clk,
  input logic      reset,
  ps2_tx_if.slave  bus
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [2:0]       r_state;
  logic [7:0]       r_sh;
  logic             r_par;
  logic [3:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack_ok;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_error;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_rise;
  logic w_accept;
  logic w_tmo_state;
  logic w_tmo_clr;
  logic w_tmo;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .i_clk_raw  (bus.ps2_clk_in),
    .i_data_raw (bus.ps2_data_in),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_fall     (w_fall),
    .o_rise     (w_rise)
  );

  assign w_accept    = bus.tx_valid && (r_state == ST_IDLE);
  assign w_tmo_state = (r_state == ST_REQ) || (r_state == ST_ACK) ||
                       (r_state == ST_WAIT_IDLE);
  // Before the first device fall, a rise can only be the echo of our own clock
  // release, so it must not restart the first-edge timeout window.
  assign w_tmo_clr   = w_fall ||
                       (w_rise && !((r_state == ST_REQ) && (r_bit_cnt == 4'd0)));
  assign w_tmo       = !w_tmo_clr && (r_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_ack_ok  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_tmo_state) begin
        if (w_tmo_clr)
          r_cnt <= '0;
        else if (r_cnt != TMO_SAT)
          r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_accept) begin
            r_sh      <= bus.tx_data;
            r_par     <= odd_parity(bus.tx_data);
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_clk_oe  <= 1'b1;
            r_state   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          // Start bit overlaps the final inhibit cycle.
          if (r_cnt == INH_PRE)
            r_data_oe <= 1'b1;
          if (r_cnt == INH_LAST) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_REQ: begin
          if (w_tmo) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
              r_data_oe <= ~r_sh[r_bit_cnt[2:0]];
            end else if (r_bit_cnt == 4'd8) begin
              r_data_oe <= ~r_par;
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (w_tmo) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (w_fall) begin
            r_ack_ok <= ~w_data_s;
            r_state  <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (w_tmo) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (w_clk_s && w_data_s) begin
            r_done  <= 1'b1;
            r_error <= ~r_ack_ok;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready    = (r_state == ST_IDLE);
  assign bus.tx_done     = r_done;
  assign bus.tx_error    = r_error;
  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: self-checking bench for ps2_tx with a behavioural PS/2 device.
// The device clocks the frame, samples data on rising edges and optionally ACKs;
// the expected frame is computed from the byte with plain arithmetic.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 2600;
  localparam int unsigned TMO = 3000;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int unsigned total    = 0;
  int unsigned bad      = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cnt  = 0;
  int unsigned done_cnt = 0;

  ps2_tx_if bus ();

  // Open-drain lines: low if either side pulls.
  assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_valid && bus.tx_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) if (bus.tx_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bits the device should see on rising edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_model(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Returns at the negedge of the first inhibit cycle.
  task automatic do_accept(input logic [7:0] b, input bit hold);
    int n = 0;
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("rdy_wait", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    chk("rdy_drop", 32'(bus.tx_ready), 32'd0);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Entered at the negedge of the first inhibit cycle.
  task automatic run_frame(input logic [7:0] b, input int half, input int mode, input bit glitch);
    int          n;
    int unsigned c0;
    logic [9:0]  got;
    logic        hold_bit;

    n = 0;
    while (bus.ps2_clk_oe && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("start_oe", 32'(bus.ps2_data_oe), 32'd1);
    c0 = cyc;

    if (mode == M_SILENT) begin
      n = 0;
      while (!bus.tx_done && n < int'(TMO) + 200) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_cycles", cyc - c0, TMO);
      chk("tmo_err", 32'(bus.tx_error), 32'd1);
      chk("tmo_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
      chk("tmo_rdy", 32'(bus.tx_ready), 32'd1);
      @(negedge clk);
      chk("tmo_1cyc", 32'(bus.tx_done), 32'd0);
      return;
    end

    chk("start_line", 32'(bus.ps2_data_in), 32'd0);
    got = '0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode == M_ACK) dev_data = 1'b0;
      repeat (half) @(negedge clk);
      if (glitch && k == 5) begin
        hold_bit = bus.ps2_data_in;
        dev_clk  = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk  = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_hold", 32'(bus.ps2_data_in), 32'(hold_bit));
        repeat (half) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (k <= 10) got[k-1] = bus.ps2_data_in;
      dev_clk = 1'b1;
      if (mode == M_ABORT && k == 4) return;
    end
    dev_data = 1'b1;
    chk("frame", 32'(got), 32'(frame_model(b)));

    n = 0;
    while (!bus.tx_done && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("done_seen", 32'(bus.tx_done), 32'd1);
    chk("err", 32'(bus.tx_error), (mode == M_NOACK) ? 32'd1 : 32'd0);
    chk("rel_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    chk("done_rdy", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    chk("done_1cyc", 32'(bus.tx_done), 32'd0);
  endtask

  initial begin
    int unsigned a0;
    int unsigned d0;
    logic [7:0]  rb;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  32'(bus.tx_ready), 32'd1);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    chk("rst_err",  32'(bus.tx_error), 32'd0);
    chk("rst_oe",   32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);

    // Set-LEDs with ACK.
    do_accept(PS2_CMD_SET_LEDS, 1'b0);
    run_frame(PS2_CMD_SET_LEDS, 45, M_ACK, 1'b0);

    // 0x00, device withholds ACK.
    do_accept(8'h00, 1'b0);
    run_frame(8'h00, 40, M_NOACK, 1'b0);

    // Device never clocks.
    do_accept(8'h3C, 1'b0);
    run_frame(8'h3C, 40, M_SILENT, 1'b0);

    // Short clock glitch mid-frame.
    do_accept(PS2_CMD_SET_LEDS, 1'b0);
    run_frame(PS2_CMD_SET_LEDS, 50, M_ACK, 1'b1);

    // tx_valid held high, data changed mid-flight.
    a0 = acc_cnt;
    do_accept(PS2_CMD_SET_LEDS, 1'b1);
    bus.tx_data = 8'h55;
    run_frame(PS2_CMD_SET_LEDS, 35, M_ACK, 1'b0);
    bus.tx_valid = 1'b0;
    run_frame(8'h55, 35, M_ACK, 1'b0);
    repeat (50) @(negedge clk);
    chk("accepts", acc_cnt - a0, 32'd2);

    // Reset during inhibit releases the clock line asynchronously.
    do_accept(PS2_CMD_SET_LEDS, 1'b0);
    repeat (100) @(negedge clk);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    chk("rst_inh_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
    chk("rst_inh_rdy", 32'(bus.tx_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_inh_nodone", done_cnt - d0, 32'd0);

    // Reset after four data bits presented.
    do_accept(8'hA5, 1'b0);
    run_frame(8'hA5, 40, M_ABORT, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_rst_data_oe", 32'(bus.ps2_data_oe), 32'd1);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    chk("rst_mid_rdy", 32'(bus.tx_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_nodone", done_cnt - d0, 32'd0);

    do_accept(PS2_CMD_RESET, 1'b0);
    run_frame(PS2_CMD_RESET, 45, M_ACK, 1'b0);

    // Randomised bytes, clock rates and ACK behaviour.
    for (int r = 0; r < 4; r++) begin
      int h;
      int m;
      rb = 8'($urandom);
      h  = int'($urandom_range(30, 60));
      m  = int'($urandom_range(0, 1));
      do_accept(rb, 1'b0);
      run_frame(rb, h, m, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
